// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues data-memory requests over a req/gnt/rvalid
// bus, aligns store data, formats load data and registers the write-back triple.
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  m_regfile_waddr_i,
  input  logic [31:0] m_regfile_rd_i,
  input  logic        m_regfile_wr_i,
  input  logic [31:0] m_data_addr_i,
  input  logic        m_data_rd_i,
  input  logic        m_data_wr_i,
  input  logic [1:0]  m_data_write_transfer_i,
  input  logic [2:0]  m_LOAD_op_i,
  input  logic        m_is_load_store_i,
  input  logic        stall_general_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [4:0]  w_regfile_waddr_o,
  output logic [31:0] w_regfile_wd_o,
  output logic        w_regfile_wr_o,
  output logic        mem_busy_o,
  output logic        misalign_o
);

  // state | meaning
  // IDLE  | no access outstanding; accepts a new access
  // REQ   | request on the bus, waiting for grant
  // RESP  | load granted, waiting for rvalid
  // DONE  | access finished but pipeline held by an unrelated stall
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        access, misaligned;
  logic [1:0]  size;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, sh, ld_fmt, ld_buf;
  logic        req_load, capture, done_load;

  assign access = m_is_load_store_i & (m_data_rd_i | m_data_wr_i);

  always_comb begin
    size = 2'd2;
    if (m_data_wr_i) begin
      size = m_data_write_transfer_i;
    end else begin
      case (m_LOAD_op_i)
        3'b000, 3'b100: size = 2'd0;
        3'b001, 3'b101: size = 2'd1;
        default:        size = 2'd2;
      endcase
    end
  end

  always_comb begin
    misaligned = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = m_regfile_rd_i;
    case (size)
      2'd0: begin
        be_d    = 4'b0001 << m_data_addr_i[1:0];
        wdata_d = {4{m_regfile_rd_i[7:0]}};
      end
      2'd1: begin
        misaligned = m_data_addr_i[0];
        be_d       = 4'b0011 << m_data_addr_i[1:0];
        wdata_d    = {2{m_regfile_rd_i[15:0]}};
      end
      default: misaligned = |m_data_addr_i[1:0];
    endcase
    misaligned = misaligned & access;
  end

  assign sh = dmem_rdata_i >> {m_data_addr_i[1:0], 3'b000};

  always_comb begin
    case (m_LOAD_op_i)
      3'b000:  ld_fmt = {{24{sh[7]}}, sh[7:0]};
      3'b100:  ld_fmt = {24'd0, sh[7:0]};
      3'b001:  ld_fmt = {{16{sh[15]}}, sh[15:0]};
      3'b101:  ld_fmt = {16'd0, sh[15:0]};
      3'b010:  ld_fmt = dmem_rdata_i;
      default: ld_fmt = 32'd0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mem_busy_o = 1'b0;
    req_load   = 1'b0;
    capture    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && misaligned) begin
          if (stall_general_i) state_d = S_DONE;
        end else if (access) begin
          mem_busy_o = 1'b1;
          req_load   = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        mem_busy_o = 1'b1;
        if (dmem_gnt_i) begin
          if (dmem_we_o) begin
            mem_busy_o = 1'b0;
            state_d    = stall_general_i ? S_DONE : S_IDLE;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        mem_busy_o = 1'b1;
        if (dmem_rvalid_i) begin
          mem_busy_o = 1'b0;
          capture    = 1'b1;
          state_d    = stall_general_i ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
        if (!stall_general_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= 32'd0;
      dmem_be_o    <= 4'd0;
      dmem_wdata_o <= 32'd0;
      ld_buf       <= 32'd0;
      done_load    <= 1'b0;
      misalign_o   <= 1'b0;
    end else begin
      state_q    <= state_d;
      misalign_o <= (state_q == S_IDLE) && misaligned;
      if (req_load) begin
        dmem_req_o   <= 1'b1;
        dmem_we_o    <= m_data_wr_i;
        dmem_addr_o  <= {m_data_addr_i[31:2], 2'b00};
        dmem_be_o    <= be_d;
        dmem_wdata_o <= wdata_d;
      end else if (state_q == S_REQ && dmem_gnt_i) begin
        dmem_req_o <= 1'b0;
      end
      // ld_buf is only meaningful for write-back while the stage parks in DONE
      if (capture) begin
        ld_buf    <= ld_fmt;
        done_load <= 1'b1;
      end else if (state_q != S_DONE) begin
        done_load <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_regfile_waddr_o <= 5'd0;
      w_regfile_wd_o    <= 32'd0;
      w_regfile_wr_o    <= 1'b0;
    end else if (!stall_general_i) begin
      w_regfile_waddr_o <= m_regfile_waddr_i;
      w_regfile_wr_o    <= m_regfile_wr_i & ~misaligned;
      if (capture)                            w_regfile_wd_o <= ld_fmt;
      else if (state_q == S_DONE && done_load) w_regfile_wd_o <= ld_buf;
      else                                    w_regfile_wd_o <= m_regfile_rd_i;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a table of accesses driven against a small
// bus responder, with expected write-back values checked through a scoreboard queue.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  m_regfile_waddr_i = '0;
  logic [31:0] m_regfile_rd_i = '0;
  logic        m_regfile_wr_i = 1'b0;
  logic [31:0] m_data_addr_i = '0;
  logic        m_data_rd_i = 1'b0;
  logic        m_data_wr_i = 1'b0;
  logic [1:0]  m_data_write_transfer_i = '0;
  logic [2:0]  m_LOAD_op_i = '0;
  logic        m_is_load_store_i = 1'b0;
  logic        stall_general;
  logic        ext_stall = 1'b0;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i = 1'b0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic [4:0]  w_regfile_waddr_o;
  logic [31:0] w_regfile_wd_o;
  logic        w_regfile_wr_o, mem_busy_o, misalign_o;

  int total = 0;
  int bad = 0;

  assign stall_general = ext_stall | mem_busy_o;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .m_regfile_waddr_i(m_regfile_waddr_i), .m_regfile_rd_i(m_regfile_rd_i),
    .m_regfile_wr_i(m_regfile_wr_i), .m_data_addr_i(m_data_addr_i),
    .m_data_rd_i(m_data_rd_i), .m_data_wr_i(m_data_wr_i),
    .m_data_write_transfer_i(m_data_write_transfer_i), .m_LOAD_op_i(m_LOAD_op_i),
    .m_is_load_store_i(m_is_load_store_i), .stall_general_i(stall_general),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .w_regfile_waddr_o(w_regfile_waddr_o), .w_regfile_wd_o(w_regfile_wd_o),
    .w_regfile_wr_o(w_regfile_wr_o), .mem_busy_o(mem_busy_o), .misalign_o(misalign_o)
  );

  typedef struct {
    bit          is_ls, rd, wr, regwr, exp_wr, chk_bus;
    logic [2:0]  op;
    logic [1:0]  size;
    logic [4:0]  waddr;
    logic [31:0] addr, data, rdata, exp_wd, exp_wdata, exp_addr;
    logic [3:0]  exp_be;
    int          gnt_dly, rv_dly, ext, exp_busy, exp_req, exp_mis;
  } vec_t;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wd;
    bit          wr;
  } wb_t;

  wb_t  sb_q[$];
  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk_ld(input logic [2:0] op, input logic [31:0] addr, rdata,
                                 input int gnt, rv, ext, input logic [31:0] wd,
                                 input logic [3:0] be, input logic [31:0] baddr,
                                 input int busy, req);
    vec_t v = '{default: 0};
    v.is_ls = 1; v.rd = 1; v.regwr = 1; v.exp_wr = 1; v.chk_bus = 1;
    v.op = op; v.addr = addr; v.rdata = rdata; v.data = 32'h0BAD_0BAD;
    v.gnt_dly = gnt; v.rv_dly = rv; v.ext = ext; v.exp_wd = wd; v.exp_be = be;
    v.exp_addr = baddr; v.exp_busy = busy; v.exp_req = req;
    return v;
  endfunction

  function automatic vec_t mk_st(input logic [1:0] size, input logic [31:0] addr, data,
                                 input int gnt, ext, input logic [3:0] be,
                                 input logic [31:0] wdata, baddr, input int busy, req);
    vec_t v = '{default: 0};
    v.is_ls = 1; v.wr = 1; v.chk_bus = 1; v.size = size; v.addr = addr; v.data = data;
    v.gnt_dly = gnt; v.ext = ext; v.exp_wd = data; v.exp_be = be; v.exp_wdata = wdata;
    v.exp_addr = baddr; v.exp_busy = busy; v.exp_req = req;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int  cyc = 0, busy_n = 0, req_n = 0, mis_n = 0, rv_wait = 0;
    bit  fired = 0, granted = 0, rv_done = 0;
    wb_t e;
    m_is_load_store_i = v.is_ls; m_data_rd_i = v.rd; m_data_wr_i = v.wr;
    m_LOAD_op_i = v.op; m_data_write_transfer_i = v.size; m_data_addr_i = v.addr;
    m_regfile_rd_i = v.data; m_regfile_wr_i = v.regwr; m_regfile_waddr_i = v.waddr;
    dmem_rdata_i = v.rdata;
    sb_q.push_back('{waddr: v.waddr, wd: v.exp_wd, wr: v.exp_wr});
    while (!fired && cyc < 100) begin
      @(negedge clk);
      ext_stall = (cyc < v.ext);
      dmem_gnt_i = 1'b0;
      dmem_rvalid_i = 1'b0;
      if (dmem_req_o) begin
        req_n++;
        dmem_gnt_i = (req_n - 1 >= v.gnt_dly);
        if (dmem_gnt_i) granted = 1;
        if (v.chk_bus) begin
          chk({nm, " addr"}, dmem_addr_o, v.exp_addr);
          chk({nm, " we"}, {31'd0, dmem_we_o}, {31'd0, v.wr});
          chk({nm, " be"}, {28'd0, dmem_be_o}, {28'd0, v.exp_be});
          if (v.wr) chk({nm, " wdata"}, dmem_wdata_o, v.exp_wdata);
        end
      end else if (granted && v.rd && !rv_done) begin
        dmem_rvalid_i = (rv_wait >= v.rv_dly);
        rv_done = dmem_rvalid_i;
        rv_wait++;
      end
      #1;
      if (mem_busy_o) busy_n++;
      if (cyc >= 1 && misalign_o) mis_n++;
      fired = !stall_general;
      @(posedge clk);
      #1;
      cyc++;
    end
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    ext_stall = 1'b0;
    if (misalign_o) mis_n++;
    if (!fired) chk({nm, " timeout"}, 32'd1, 32'd0);
    if (sb_q.size() == 0) begin
      chk({nm, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({nm, " wb_waddr"}, {27'd0, w_regfile_waddr_o}, {27'd0, e.waddr});
      chk({nm, " wb_wd"}, w_regfile_wd_o, e.wd);
      chk({nm, " wb_wr"}, {31'd0, w_regfile_wr_o}, {31'd0, e.wr});
    end
    chk({nm, " busy_cycles"}, 32'(busy_n), 32'(v.exp_busy));
    chk({nm, " req_cycles"}, 32'(req_n), 32'(v.exp_req));
    chk({nm, " misalign_pulses"}, 32'(mis_n), 32'(v.exp_mis));
  endtask

  initial begin
    vecs[0]  = mk_ld(3'b010, 32'h100, 32'h8765_4321, 0, 3, 0, 32'h8765_4321, 4'hF, 32'h100, 5, 1);
    vecs[1]  = mk_ld(3'b000, 32'h103, 32'h80FF_FFFF, 0, 0, 0, 32'hFFFF_FF80, 4'h8, 32'h100, 2, 1);
    vecs[2]  = mk_ld(3'b100, 32'h103, 32'h80FF_FFFF, 0, 0, 0, 32'h0000_0080, 4'h8, 32'h100, 2, 1);
    vecs[3]  = mk_ld(3'b001, 32'h102, 32'h7FFF_0000, 0, 0, 0, 32'h0000_7FFF, 4'hC, 32'h100, 2, 1);
    vecs[4]  = mk_st(2'd1, 32'h106, 32'h1234_ABCD, 2, 0, 4'hC, 32'hABCD_ABCD, 32'h104, 3, 3);
    vecs[5]  = mk_ld(3'b010, 32'h101, 32'h0, 0, 0, 0, 32'h0BAD_0BAD, 4'h0, 32'h0, 0, 0);
    vecs[5].exp_wr = 0; vecs[5].chk_bus = 0; vecs[5].exp_mis = 1;
    vecs[6]  = '{default: 0};
    vecs[6].data = 32'hDEAD_BEEF; vecs[6].regwr = 1; vecs[6].exp_wr = 1;
    vecs[6].exp_wd = 32'hDEAD_BEEF;
    vecs[7]  = mk_ld(3'b101, 32'h100, 32'h1234_F00D, 1, 1, 0, 32'h0000_F00D, 4'h3, 32'h100, 4, 2);
    vecs[8]  = mk_st(2'd0, 32'h203, 32'h0000_00A5, 0, 0, 4'h8, 32'hA5A5_A5A5, 32'h200, 1, 1);
    vecs[9]  = mk_st(2'd2, 32'h300, 32'hCAFE_F00D, 0, 0, 4'hF, 32'hCAFE_F00D, 32'h300, 1, 1);
    vecs[10] = mk_ld(3'b010, 32'h040, 32'h1357_9BDF, 0, 0, 7, 32'h1357_9BDF, 4'hF, 32'h040, 2, 1);
    vecs[11] = mk_ld(3'b001, 32'h100, 32'h0000_8001, 0, 0, 0, 32'hFFFF_8001, 4'h3, 32'h100, 2, 1);
    vecs[12] = mk_ld(3'b011, 32'h104, 32'hFFFF_FFFF, 0, 0, 0, 32'h0, 4'h0, 32'h104, 2, 1);
    vecs[12].chk_bus = 0;
    vecs[13] = mk_st(2'd2, 32'h302, 32'h0000_0077, 0, 3, 4'h0, 32'h0, 32'h0, 0, 0);
    vecs[13].regwr = 1; vecs[13].chk_bus = 0; vecs[13].exp_mis = 1;
    vecs[14] = mk_ld(3'b000, 32'h101, 32'h0000_7F00, 0, 0, 0, 32'h0000_007F, 4'h2, 32'h100, 2, 1);
    for (int i = 0; i < 15; i++) vecs[i].waddr = 5'(i + 1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst req", {31'd0, dmem_req_o}, 32'd0);
    chk("rst be", {28'd0, dmem_be_o}, 32'd0);
    chk("rst wdata", dmem_wdata_o, 32'd0);
    chk("rst wd", w_regfile_wd_o, 32'd0);
    chk("rst wr", {31'd0, w_regfile_wr_o}, 32'd0);
    chk("rst busy", {31'd0, mem_busy_o}, 32'd0);
    chk("rst misalign", {31'd0, misalign_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // reset while a load sits in RESP; a late rvalid must not leak into write-back
    m_is_load_store_i = 1; m_data_rd_i = 1; m_data_wr_i = 0; m_LOAD_op_i = 3'b010;
    m_data_addr_i = 32'h80; m_regfile_wr_i = 1; m_regfile_waddr_i = 5'd9;
    m_regfile_rd_i = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("rstseq req", {31'd0, dmem_req_o}, 32'd1);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    #1;
    chk("rstseq resp busy", {31'd0, mem_busy_o}, 32'd1);
    rst_n = 1'b0;
    m_is_load_store_i = 0; m_data_rd_i = 0; m_regfile_wr_i = 0;
    #1;
    chk("rstseq req0", {31'd0, dmem_req_o}, 32'd0);
    chk("rstseq wd0", w_regfile_wd_o, 32'd0);
    chk("rstseq waddr0", {27'd0, w_regfile_waddr_o}, 32'd0);
    chk("rstseq addr0", dmem_addr_o, 32'd0);
    chk("rstseq busy0", {31'd0, mem_busy_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_regfile_rd_i = 32'h11; m_regfile_wr_i = 1; m_regfile_waddr_i = 5'd3;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    dmem_rvalid_i = 1'b0;
    chk("late rvalid wd", w_regfile_wd_o, 32'h11);
    chk("late rvalid wr", {31'd0, w_regfile_wr_o}, 32'd1);
    run_vec(vecs[0], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and write-back. Consumes the registered execute outputs (address, store data, load/store flags, transfer size, load op, destination register) and performs the data-memory access over a request/grant/valid bus. It aligns store data into byte lanes, extracts and sign- or zero-extends load data, and raises a stall while an access is outstanding. It then registers the write-back triple for the register file.

## Interface
- `clk`, `rst_n`: reset is asynchronous and active-low (`rst_n`); clock is `clk`.
- No parameters. Data width is 32. `MEM_TRANSFER_WIDTH` is 2 (0 = byte, 1 = half, 2 = word). `LOAD_OP_WIDTH` is 3.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `m_regfile_waddr_i` in 5: destination register.
- `m_regfile_rd_i` in 32: ALU/pc result for non-memory ops; store data for stores.
- `m_regfile_wr_i` in 1: register write enable.
- `m_data_addr_i` in 32: byte address.
- `m_data_rd_i` in 1: load request.
- `m_data_wr_i` in 1: store request.
- `m_data_write_transfer_i` in 2: store size.
- `m_LOAD_op_i` in 3: load op. 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `m_is_load_store_i` in 1: memory instruction valid.
- `stall_general_i` in 1: global stall. It already ORs in `mem_busy_o`.
- `dmem_req_o` out 1: bus request.
- `dmem_we_o` out 1: 1 for store.
- `dmem_addr_o` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dmem_be_o` out 4: byte enables.
- `dmem_wdata_o` out 32: lane-replicated store data.
- `dmem_gnt_i` in 1: request accepted this cycle.
- `dmem_rvalid_i` in 1: load data valid.
- `dmem_rdata_i` in 32: load word.
- `w_regfile_waddr_o` out 5: write-back address.
- `w_regfile_wd_o` out 32: write-back data.
- `w_regfile_wr_o` out 1: write-back enable.
- `mem_busy_o` out 1: combinational stall request.
- `misalign_o` out 1: registered one-cycle pulse on a misaligned access.

## Operation
- An access exists when `m_is_load_store_i & (m_data_rd_i | m_data_wr_i)`. Inputs stay stable while `stall_general_i` is high.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE: on an aligned access, `mem_busy_o`=1 and go to REQ. On a misaligned access, pulse `misalign_o`, issue no bus request, keep `mem_busy_o`=0, and go to DONE if `stall_general_i` else stay in IDLE.
  - REQ: drive `dmem_req_o`=1 plus `we`/`addr`/`be`/`wdata` until `dmem_gnt_i`. `mem_busy_o`=1 except in the grant cycle of a store. Store plus grant goes to DONE if `stall_general_i` else IDLE. Load plus grant goes to RESP.
  - RESP: `mem_busy_o`=1 until `dmem_rvalid_i`. On rvalid, format the data and capture it into `ld_buf`, set `mem_busy_o`=0, then go to DONE if `stall_general_i` else IDLE.
  - DONE: completed access held by an unrelated stall. `mem_busy_o`=0 and no re-issue. Go to IDLE when `!stall_general_i`.
- Alignment: half requires `addr[0]`=0; word requires `addr[1:0]`=0.
- Byte enables: byte is `4'b0001<<addr[1:0]`; half is `4'b0011<<addr[1:0]`; word is `4'b1111`.
- Store data: byte is `{4{d[7:0]}}`; half is `{2{d[15:0]}}`; word is `d`.
- Load: `sh = rdata >> (8*addr[1:0])`. LB sign-extends `sh[7:0]`; LBU zero-extends it. LH sign-extends `sh[15:0]`; LHU zero-extends it. LW uses the full word. Undefined op codes return 0.
- Write-back registers update only when `!stall_general_i`:
  - `waddr` comes from `m_regfile_waddr_i`.
  - `wr` is `m_regfile_wr_i & !misaligned`.
  - `wd` is the formatted `rdata` in an rvalid cycle, `ld_buf` for a load completed earlier (DONE), and otherwise `m_regfile_rd_i`.

## Timing
- All outputs reset to 0 and the state resets to IDLE, even mid-transaction. `dmem_req_o` drops asynchronously and a pending rvalid is ignored.
- Load with immediate grant and rvalid one cycle later: cycle 0 IDLE (busy), cycle 1 REQ plus gnt, cycle 2 rvalid (busy=0). The write-back registers show the data after edge 2. Total 3 cycles.
- Store with immediate grant: cycle 0 IDLE (busy), cycle 1 REQ plus gnt (busy=0). The write-back registers update at edge 1.
- Non-memory op: 1 cycle, no busy.
- Grant wait states stretch REQ. rvalid wait states stretch RESP. Signals on the `dmem_*` outputs are held constant while `dmem_req_o` is high and `dmem_gnt_i` is low.
- rvalid is never accepted outside RESP.
- `mem_busy_o` is combinational from state and inputs. Every other output is registered.

## Test plan
- LW at addr 0x100 with `rdata`=0x8765_4321, gnt immediate, rvalid after 3 wait cycles -> busy for 5 cycles, `dmem_addr_o`=0x100, then `w_regfile_wd_o`=0x8765_4321 with `wr`=1.
- LB / LBU at addr 0x103 with `rdata`=0x80FF_FFFF -> LB gives 0xFFFF_FF80; LBU gives 0x0000_0080. LH at 0x102 with `rdata`=0x7FFF_0000 gives 0x0000_7FFF.
- SH of 0x1234ABCD at 0x106, gnt delayed 2 cycles -> `dmem_be_o`=4'b1100, `dmem_wdata_o`=0xABCD_ABCD, `dmem_addr_o`=0x104, `dmem_we_o`=1. Request is held for 3 cycles and there is no rvalid wait.
- Misaligned LW at 0x101 -> no `dmem_req_o`, `misalign_o` pulses once, `w_regfile_wr_o`=0, busy never asserts.
- Load completes while `stall_general_i` is held high for 4 more cycles -> single bus request. Write-back gives the `ld_buf` value when the stall releases.
- Assert `rst_n` low in RESP -> all outputs 0 and state IDLE. A late rvalid is ignored. A new access after reset works normally.
